// File: rtl/raster_pkg.sv
// Shared widths, FSM encoding, fragment record and min/max helpers for the
// raster scan controller. Optional build macro: RASTER_ROW_EARLY_EXIT_EN.
package raster_pkg;

    localparam int COORD_W  = 9;
    localparam int PIX_W    = 10;
    localparam int DEPTH_W  = 7;
    localparam int WEIGHT_W = 18;
    localparam int AW_W     = 19;

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, FLUSH} raster_scan_state_t;

    typedef struct packed {
        logic [PIX_W-1:0]    x;
        logic [PIX_W-1:0]    y;
        logic [WEIGHT_W-1:0] uw;
        logic [WEIGHT_W-1:0] vw;
        logic [WEIGHT_W-1:0] ww;
        logic [AW_W-1:0]     aw;
    } raster_frag_t;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/raster_bbox.sv
// Combinational screen-clipped bounding box of three vertices.
// Only the max edges need clamping: coordinates are unsigned, so min >= 0.
module raster_bbox
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    output logic [PIX_W-1:0]   xmin,
    output logic [PIX_W-1:0]   xmax,
    output logic [PIX_W-1:0]   ymin,
    output logic [PIX_W-1:0]   ymax,
    output logic               empty
);

    localparam logic [PIX_W-1:0] XLIM = PIX_W'(SCREEN_W - 1);
    localparam logic [PIX_W-1:0] YLIM = PIX_W'(SCREEN_H - 1);

    logic [PIX_W-1:0] xmax_raw, ymax_raw;

    // min/max, clamp to screen, flag boxes that lie fully off-screen
    always_comb begin
        xmin     = PIX_W'(min3(ax, bx, cx));
        ymin     = PIX_W'(min3(ay, by, cy));
        xmax_raw = PIX_W'(max3(ax, bx, cx));
        ymax_raw = PIX_W'(max3(ay, by, cy));
        xmax     = (xmax_raw > XLIM) ? XLIM : xmax_raw;
        ymax     = (ymax_raw > YLIM) ? YLIM : ymax_raw;
        empty    = (xmin > xmax) || (ymin > ymax);
    end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Triangle scan sequencer: latches a triangle, registers its clipped bounding
// box, walks it row-major feeding the external rasterizer and emits one
// fragment per covered pixel through a single backpressured output register.
// Optional build macro: RASTER_ROW_EARLY_EXIT_EN (end a row at the first
// uncovered pixel after a covered one; relies on triangle convexity).
module raster_scan_ctrl
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tri_valid,
    output logic                tri_ready,
    input  logic [COORD_W-1:0]  tri_ax,
    input  logic [COORD_W-1:0]  tri_ay,
    input  logic [COORD_W-1:0]  tri_bx,
    input  logic [COORD_W-1:0]  tri_by,
    input  logic [COORD_W-1:0]  tri_cx,
    input  logic [COORD_W-1:0]  tri_cy,
    input  logic [DEPTH_W-1:0]  tri_bz,
    input  logic [DEPTH_W-1:0]  tri_cz,
    output logic [COORD_W-1:0]  rz_ax,
    output logic [COORD_W-1:0]  rz_ay,
    output logic [COORD_W-1:0]  rz_bx,
    output logic [COORD_W-1:0]  rz_by,
    output logic [COORD_W-1:0]  rz_cx,
    output logic [COORD_W-1:0]  rz_cy,
    output logic [DEPTH_W-1:0]  rz_bz,
    output logic [DEPTH_W-1:0]  rz_cz,
    output logic [PIX_W-1:0]    rz_x,
    output logic [PIX_W-1:0]    rz_y,
    input  logic [WEIGHT_W-1:0] rz_uw,
    input  logic [WEIGHT_W-1:0] rz_vw,
    input  logic [WEIGHT_W-1:0] rz_ww,
    input  logic [AW_W-1:0]     rz_aw,
    input  logic                rz_visible,
    output logic                frag_valid,
    input  logic                frag_ready,
    output logic [PIX_W-1:0]    frag_x,
    output logic [PIX_W-1:0]    frag_y,
    output logic [WEIGHT_W-1:0] frag_uw,
    output logic [WEIGHT_W-1:0] frag_vw,
    output logic [WEIGHT_W-1:0] frag_ww,
    output logic [AW_W-1:0]     frag_aw,
    output logic                tri_done
);

    raster_scan_state_t state, nstate;

    logic [PIX_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic             bb_empty;
    logic [PIX_W-1:0] x_min, x_max, y_max;
    raster_frag_t     frag_q;

    logic adv, accept, scan_adv, flush_done;
    logic last_x, last_y, row_end;

    raster_bbox #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_bbox (
        .ax(rz_ax), .ay(rz_ay), .bx(rz_bx), .by(rz_by), .cx(rz_cx), .cy(rz_cy),
        .xmin(bb_xmin), .xmax(bb_xmax), .ymin(bb_ymin), .ymax(bb_ymax),
        .empty(bb_empty)
    );

`ifdef RASTER_ROW_EARLY_EXIT_EN
    logic seen_inside;

    // remember whether the current row has entered the triangle yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          seen_inside <= 1'b0;
        else if (state == SETUP) seen_inside <= 1'b0;
        else if (scan_adv)   seen_inside <= row_end ? 1'b0 : (seen_inside | rz_visible);
    end
`endif

    // row/box end detection for the current scan pixel
    always_comb begin
        last_x  = (rz_x == x_max);
        last_y  = (rz_y == y_max);
`ifdef RASTER_ROW_EARLY_EXIT_EN
        row_end = last_x || (seen_inside && !rz_visible);
`else
        row_end = last_x;
`endif
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // next-state logic
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (tri_valid) nstate = SETUP;
            SETUP:   nstate = bb_empty ? FLUSH : SCAN;
            SCAN:    if (adv && row_end && last_y) nstate = FLUSH;
            FLUSH:   if (adv) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // state-decoded controls; adv means the output register can take a new value
    always_comb begin
        adv        = !frag_valid || frag_ready;
        tri_ready  = (state == IDLE);
        accept     = (state == IDLE) && tri_valid;
        scan_adv   = (state == SCAN) && adv;
        flush_done = (state == FLUSH) && adv;
    end

    // triangle latch, held stable for the rasterizer for the whole scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rz_ax, rz_ay, rz_bx, rz_by, rz_cx, rz_cy} <= '0;
            {rz_bz, rz_cz} <= '0;
        end else if (accept) begin
            {rz_ax, rz_ay, rz_bx, rz_by, rz_cx, rz_cy} <=
                {tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy};
            {rz_bz, rz_cz} <= {tri_bz, tri_cz};
        end
    end

    // box capture in SETUP, then row-major stepping; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {x_min, x_max, y_max} <= '0;
            rz_x <= '0;
            rz_y <= '0;
        end else if (state == SETUP) begin
            {x_min, x_max, y_max} <= {bb_xmin, bb_xmax, bb_ymax};
            if (!bb_empty) begin
                rz_x <= bb_xmin;
                rz_y <= bb_ymin;
            end
        end else if (scan_adv) begin
            if (!row_end) begin
                rz_x <= rz_x + 1'b1;
            end else if (!last_y) begin
                rz_x <= x_min;
                rz_y <= rz_y + 1'b1;
            end
        end
    end

    // output register: load on covered pixel, drop on accept without refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frag_valid <= 1'b0;
            frag_q     <= '0;
        end else if (scan_adv) begin
            frag_valid <= rz_visible;
            if (rz_visible) frag_q <= '{rz_x, rz_y, rz_uw, rz_vw, rz_ww, rz_aw};
        end else if (frag_ready) begin
            frag_valid <= 1'b0;
        end
    end

    // completion pulse once the scan and the last handshake are finished
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tri_done <= 1'b0;
        else        tri_done <= flush_done;
    end

    assign {frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw} = frag_q;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: edge-function rasterizer environment plus a
// box-walk reference that lists the expected fragments of each triangle.
module tb_raster_scan_ctrl;

    localparam int SW = 480;
    localparam int SH = 240;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [17:0] u;
        logic [17:0] v;
        logic [17:0] w;
        logic [18:0] a;
    } frag_t;

    typedef struct packed {
        logic vis;
        int   u;
        int   v;
        int   w;
        int   a;
    } rast_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [8:0]  tri_ax = '0, tri_ay = '0, tri_bx = '0, tri_by = '0, tri_cx = '0, tri_cy = '0;
    logic [6:0]  tri_bz = '0, tri_cz = '0;
    logic [8:0]  rz_ax, rz_ay, rz_bx, rz_by, rz_cx, rz_cy;
    logic [6:0]  rz_bz, rz_cz;
    logic [9:0]  rz_x, rz_y;
    logic [17:0] rz_uw, rz_vw, rz_ww;
    logic [18:0] rz_aw;
    logic        rz_visible;
    logic        frag_valid;
    logic        frag_ready = 1'b0;
    logic [9:0]  frag_x, frag_y;
    logic [17:0] frag_uw, frag_vw, frag_ww;
    logic [18:0] frag_aw;
    logic        tri_done;

    int    checks = 0;
    int    failures = 0;
    frag_t exp_q[$];
    rast_t rr;

    raster_scan_ctrl #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .rst_n(rst_n),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_ax(tri_ax), .tri_ay(tri_ay), .tri_bx(tri_bx), .tri_by(tri_by),
        .tri_cx(tri_cx), .tri_cy(tri_cy), .tri_bz(tri_bz), .tri_cz(tri_cz),
        .rz_ax(rz_ax), .rz_ay(rz_ay), .rz_bx(rz_bx), .rz_by(rz_by),
        .rz_cx(rz_cx), .rz_cy(rz_cy), .rz_bz(rz_bz), .rz_cz(rz_cz),
        .rz_x(rz_x), .rz_y(rz_y),
        .rz_uw(rz_uw), .rz_vw(rz_vw), .rz_ww(rz_ww), .rz_aw(rz_aw),
        .rz_visible(rz_visible),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y),
        .frag_uw(frag_uw), .frag_vw(frag_vw), .frag_ww(frag_ww), .frag_aw(frag_aw),
        .tri_done(tri_done)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // inclusive-edge coverage test with barycentric edge weights
    function automatic rast_t raster(input int ax, input int ay, input int bx, input int by,
                                     input int cx, input int cy, input int px, input int py);
        rast_t r;
        r.a = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
        r.u = (cx - bx) * (py - by) - (cy - by) * (px - bx);
        r.v = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
        r.w = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
        if (r.a > 0)      r.vis = (r.u >= 0) && (r.v >= 0) && (r.w >= 0);
        else if (r.a < 0) r.vis = (r.u <= 0) && (r.v <= 0) && (r.w <= 0);
        else              r.vis = 1'b0;
        r.u = iabs(r.u); r.v = iabs(r.v); r.w = iabs(r.w); r.a = iabs(r.a);
        return r;
    endfunction

    // rasterizer environment driven by the controller's latched triangle
    always_comb begin
        rr = raster(int'(rz_ax), int'(rz_ay), int'(rz_bx), int'(rz_by),
                    int'(rz_cx), int'(rz_cy), int'(rz_x), int'(rz_y));
        rz_visible = rr.vis;
        rz_uw = rr.u[17:0];
        rz_vw = rr.v[17:0];
        rz_ww = rr.w[17:0];
        rz_aw = rr.a[18:0];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // expected fragment list: every covered pixel of the clipped box, row-major
    task automatic build_exp(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, output int box_px);
        int xmin, xmax, ymin, ymax;
        rast_t r;
        exp_q.delete();
        xmin = (ax < bx) ? ax : bx; xmin = (cx < xmin) ? cx : xmin;
        ymin = (ay < by) ? ay : by; ymin = (cy < ymin) ? cy : ymin;
        xmax = (ax > bx) ? ax : bx; xmax = (cx > xmax) ? cx : xmax;
        ymax = (ay > by) ? ay : by; ymax = (cy > ymax) ? cy : ymax;
        if (xmax > SW - 1) xmax = SW - 1;
        if (ymax > SH - 1) ymax = SH - 1;
        box_px = (xmin > xmax || ymin > ymax) ? 0 : (xmax - xmin + 1) * (ymax - ymin + 1);
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                r = raster(ax, ay, bx, by, cx, cy, x, y);
                if (r.vis) exp_q.push_back('{x[9:0], y[9:0], r.u[17:0], r.v[17:0], r.w[17:0], r.a[18:0]});
            end
    endtask

    task automatic accept_tri(input int ax, input int ay, input int bx, input int by,
                              input int cx, input int cy, input int bz, input int cz);
        tri_ax = 9'(ax); tri_ay = 9'(ay); tri_bx = 9'(bx);
        tri_by = 9'(by); tri_cx = 9'(cx); tri_cy = 9'(cy);
        tri_bz = 7'(bz); tri_cz = 7'(cz);
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready
    task automatic run_tri(input string tag, input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy, input int mode,
                           output int edges, output int got, output int box_px, output int maxx);
        int    n_exp;
        bit    done, held_v, fv, fr;
        frag_t held, cur, e;
        int    bz, cz;
        build_exp(ax, ay, bx, by, cx, cy, box_px);
        n_exp = exp_q.size();
        bz = int'($urandom_range(0, 127));
        cz = int'($urandom_range(0, 127));
        chk({tag, " idle ready"}, tri_ready, 1'b1);
        accept_tri(ax, ay, bx, by, cx, cy, bz, cz);
        chk({tag, " latch"}, {rz_ax, rz_ay, rz_bx, rz_by, rz_cx, rz_cy, rz_bz, rz_cz},
            {9'(ax), 9'(ay), 9'(bx), 9'(by), 9'(cx), 9'(cy), 7'(bz), 7'(cz)});
        chk({tag, " busy not ready"}, tri_ready, 1'b0);
        edges = 0; got = 0; maxx = 0; done = 0; held_v = 0; held = '0;
        while (!done && edges < 20000) begin
            case (mode)
                0:       frag_ready = 1'b1;
                1:       frag_ready = (edges % 3 == 0);
                default: frag_ready = 1'($urandom_range(0, 1));
            endcase
            cur = {frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw};
            if (held_v) chk({tag, " stall hold"}, {frag_valid, cur}, {1'b1, held});
            fv = frag_valid; fr = frag_ready;
            held_v = fv && !fr; held = cur;
            if (int'(rz_x) > maxx) maxx = int'(rz_x);
            @(posedge clk);
            if (fv && fr) begin
                got++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, " frag"}, cur, e);
                end
            end
            #1;
            edges++;
            if (tri_done) done = 1'b1;
        end
        chk({tag, " tri_done seen"}, done, 1'b1);
        chk({tag, " frag count"}, got, n_exp);
        frag_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " tri_done single pulse"}, tri_done, 1'b0);
    endtask

    initial begin
        int edges, got, box, maxx, n;
        int bx0, by0;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset tri_ready", tri_ready, 1'b1);
        chk("reset frag_valid", frag_valid, 1'b0);
        chk("reset tri_done", tri_done, 1'b0);
        chk("reset rz_xy", {rz_x, rz_y}, 20'd0);
        chk("reset latch", {rz_ax, rz_ay, rz_bx, rz_by, rz_cx, rz_cy, rz_bz, rz_cz}, 68'd0);
        chk("reset frag data", {frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw}, 93'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // reference triangle, full throughput
        run_tri("tri1", 10, 10, 20, 10, 10, 20, 0, edges, got, box, maxx);
        chk("tri1 fragments", got, 66);
`ifdef RASTER_ROW_EARLY_EXIT_EN
        chk("tri1 scan cycles fewer", (edges - 2) < 121, 1'b1);
`else
        chk("tri1 scan cycles", edges - 2, 121);
`endif

        // same triangle, ready one cycle in three
        run_tri("tri1 bp", 10, 10, 20, 10, 10, 20, 1, edges, got, box, maxx);
        chk("tri1 bp fragments", got, 66);

        // collinear: whole box scanned, nothing covered
        run_tri("collinear", 0, 0, 5, 5, 10, 10, 0, edges, got, box, maxx);
        chk("collinear fragments", got, 0);
        chk("collinear scan cycles", edges - 2, 121);

        // x clamp at the right screen edge
        run_tri("xclamp", 470, 5, 500, 5, 470, 9, 0, edges, got, box, maxx);
        chk("xclamp rz_x bound", maxx <= SW - 1, 1'b1);
`ifdef RASTER_ROW_EARLY_EXIT_EN
        chk("xclamp scan cycles", (edges - 2) <= box, 1'b1);
`else
        chk("xclamp scan cycles", edges - 2, box);
`endif

        // y clamp at the bottom edge, random backpressure
        run_tri("yclamp", 10, 230, 20, 230, 15, 250, 2, edges, got, box, maxx);

        // box fully off-screen: straight to completion
        run_tri("offscreen", 490, 10, 500, 10, 495, 20, 0, edges, got, box, maxx);
        chk("offscreen fragments", got, 0);
        chk("offscreen cycles", edges, 2);

        // reset in the middle of a scan
        build_exp(10, 10, 20, 10, 10, 20, box);
        frag_ready = 1'b1;
        accept_tri(10, 10, 20, 10, 10, 20, 1, 2);
        n = 0;
        while (!(rz_x == 10'd15 && rz_y == 10'd12) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midscan reached (15,12)", {rz_x, rz_y}, {10'd15, 10'd12});
        chk("midscan frag pending", frag_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midscan reset frag_valid", frag_valid, 1'b0);
        chk("midscan reset tri_ready", tri_ready, 1'b1);
        chk("midscan reset rz_xy", {rz_x, rz_y}, 20'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_tri("after reset", 30, 40, 45, 42, 33, 55, 0, edges, got, box, maxx);

        // random triangles with random backpressure
        for (int i = 0; i < 6; i++) begin
            bx0 = int'($urandom_range(0, 470));
            by0 = int'($urandom_range(0, 235));
            run_tri("random",
                    bx0 + int'($urandom_range(0, 24)), by0 + int'($urandom_range(0, 24)),
                    bx0 + int'($urandom_range(0, 24)), by0 + int'($urandom_range(0, 24)),
                    bx0 + int'($urandom_range(0, 24)), by0 + int'($urandom_range(0, 24)),
                    2, edges, got, box, maxx);
            chk("random rz_x bound", maxx <= SW - 1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
